sync_fifo_param: RTL
====================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: number of entries; a power of two, at least 4.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2: almost_full asserts when fifo_cnt >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 2: almost_empty asserts when fifo_cnt <= AE_LEVEL.
REQ-005 SHALL have parameter FWFT, default 0: 0 = registered-read mode; 1 = first-word-fall-through mode.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port clr, input, 1 bit: synchronous flush; storage contents are not cleared.
REQ-009 SHALL have port wr, input, 1 bit: write request.
REQ-010 SHALL have port data_in, input, WIDTH bits: write data.
REQ-011 SHALL have port rd, input, 1 bit: read request.
REQ-012 SHALL have port data_out, output, WIDTH bits: read data.
REQ-013 SHALL have ports empty and full, output, 1 bit each: occupancy flags.
REQ-014 SHALL have ports almost_empty and almost_full, output, 1 bit each: threshold flags.
REQ-015 SHALL have port fifo_cnt, output, $clog2(DEPTH)+1 bits: current occupancy, range 0..DEPTH.
REQ-016 SHALL have ports overflow and underflow, output, 1 bit each: sticky error flags.

Function
REQ-017 SHALL accept a write on a rising edge when wr=1 and (full=0 or a read is accepted on the same edge).
REQ-018 SHALL accept a read on a rising edge when rd=1 and empty=0; a read on an empty FIFO is never accepted, even with a simultaneous write.
REQ-019 SHALL use read/write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0 with no gap.
REQ-020 SHALL update fifo_cnt each edge: +1 for a write only, -1 for a read only, unchanged for both or neither.
REQ-021 SHALL drive empty, full, almost_empty and almost_full as decodes of the registered fifo_cnt, with no combinational path from wr or rd.
REQ-022 When FWFT=0, SHALL load data_out with the head word on the edge that accepts the read, and SHALL hold data_out otherwise.
REQ-023 When FWFT=1, SHALL present the head word on data_out whenever empty=0; an accepted read advances to the next word on the following cycle.
REQ-024 When FWFT=1, the first word written into an empty FIFO SHALL appear on data_out one cycle after the write edge.
REQ-025 SHALL set overflow on a wr=1 edge that is not accepted, and set underflow on a rd=1 edge that is not accepted.
REQ-026 overflow and underflow SHALL remain set until rst or clr.
REQ-027 On clr=1, SHALL zero the pointers, fifo_cnt, overflow and underflow, and SHALL ignore wr and rd on that edge.
REQ-028 On clr=1, SHALL leave data_out unchanged in FWFT=0 mode.
REQ-029 Accepted writes SHALL be returned in write order with no loss or duplication across pointer wrap-around.

Reset
REQ-030 On rst=1 at a rising edge, SHALL clear: pointers, fifo_cnt=0, data_out=0, overflow=0, underflow=0.
REQ-031 After reset, flags SHALL read empty=1, almost_empty=1, full=0, almost_full=0.
REQ-032 rst SHALL take priority over clr, wr and rd.
REQ-033 Reset asserted mid-operation SHALL discard all contents; the first read after reset returns the first word written after reset.
REQ-034 The storage array SHALL NOT be reset.

Structure
REQ-035 SHALL place the default WIDTH/DEPTH constants and the FWFT mode encodings in the shared package fifo_pkg.
REQ-036 SHALL instantiate one sub-module, fifo_ram: a simple dual-port array with synchronous write and asynchronous read, parameterised by WIDTH and DEPTH.
REQ-037 SHALL keep all control logic (pointers, count, flags, error bits, output register) in sync_fifo_param.

Verification
REQ-038 Defaults, FWFT=0: reset, write 1 then 2, read twice -> data_out=1 then 2; fifo_cnt returns to 0; empty=1.
REQ-039 Fill: write 10,20,...,160 (16 words) -> full=1 and fifo_cnt=16; almost_full first asserts at count 14.
REQ-040 Overflow: with full=1, write 170 -> overflow=1 stays set; fifo_cnt stays 16; then read 16 words -> 10..160 in order.
REQ-041 Simultaneous access: wr=1 and rd=1 on the same edge when full -> fifo_cnt stays 16 and the new word is stored.
REQ-042 Simultaneous access on empty: wr=1 and rd=1 on the same edge when empty -> fifo_cnt=1, underflow=1.
REQ-043 Wrap-around: perform 40 interleaved push/pop pairs with data 0..39 -> output sequence is 0..39 exactly; clr mid-stream -> empty=1 and error flags cleared.
REQ-044 FWFT=1: write 5 into an empty FIFO -> data_out=5 one cycle later with no rd; rd=1 -> empty=1 on the next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants for the synchronous FIFO slice:
//   - default data width and depth
//   - read-mode encodings for the FWFT parameter
// No ports; imported by fifo_ram and sync_fifo_param.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Read-mode encodings for the FWFT parameter.
  localparam int FWFT_REGISTERED  = 0;  // data_out loads on an accepted read
  localparam int FWFT_FALLTHROUGH = 1;  // head word is always visible on data_out

endpackage

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// Simple dual-port storage array: one synchronous write port, one
// asynchronous (combinational) read port.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data, combinational from raddr
// -----------------------------------------------------------------------------
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset on purpose; pointers and count define which
  // entries are valid, and a reset here would prevent mapping onto RAM cells.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO with occupancy/threshold flags, sticky error flags and
// selectable registered-read or first-word-fall-through output.
// Ports:
//   clk          - clock, rising edge
//   rst          - synchronous active-high reset (highest priority)
//   clr          - synchronous flush; wr/rd ignored on that edge
//   wr, data_in  - write request and data
//   rd           - read request
//   data_out     - read data (registered, or head word in FWFT mode)
//   empty, full  - occupancy flags
//   almost_empty - fifo_cnt <= AE_LEVEL
//   almost_full  - fifo_cnt >= AF_LEVEL
//   fifo_cnt     - occupancy 0..DEPTH
//   overflow     - sticky: a write was refused
//   underflow    - sticky: a read was refused
// -----------------------------------------------------------------------------
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FWFT_REGISTERED
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wr,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   rd,
  output logic [WIDTH-1:0]       data_out,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] dout_q;
  logic             ovf_q;
  logic             udf_q;
  logic             wr_ok;
  logic             rd_ok;

  // Acceptance. A read needs a non-empty FIFO regardless of a concurrent
  // write; a write into a full FIFO is allowed only when a read frees a slot
  // on the same edge. Nothing is accepted on a reset or flush edge.
  // NOTE: every signal driven here is assigned on every path, so no latch
  // can be inferred; always_comb outputs need a value in all branches.
  always_comb begin
    rd_ok = rd && !empty && !clr && !rst;
    wr_ok = wr && (!full || rd_ok) && !clr && !rst;
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (clr) begin
      // Flush keeps dout_q so the last read word stays visible.
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      // DEPTH is a power of two, so the natural AW-bit wrap is gap-free.
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout_q <= head;
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (wr && !wr_ok) begin
        ovf_q <= 1'b1;
      end
      if (rd && !rd_ok) begin
        udf_q <= 1'b1;
      end
    end
  end

  // Flags decode only the registered count: no path from wr/rd.
  assign empty        = (cnt == '0);
  assign full         = (cnt == CW'(DEPTH));
  assign almost_empty = (cnt <= CW'(AE_LEVEL));
  assign almost_full  = (cnt >= CW'(AF_LEVEL));
  assign fifo_cnt     = cnt;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // In fall-through mode the head entry is shown directly; it is forced to
  // zero while empty so stale storage never leaks out after reset or flush.
  assign data_out = (FWFT == FWFT_FALLTHROUGH) ? (empty ? '0 : head) : dout_q;

endmodule
